// File: rtl/phv_out_fifo.sv
// -----------------------------------------------------------------------------
// phv_out_fifo
//
// Receive-side buffer between the last pipeline stage and the deparser.
// PHVs are stored in arrival order and presented first-word-fall-through.
// The producer does not wait for ready and may still have up to SKID PHVs
// in flight after phv_fifo_ready falls. Ready therefore drops while SKID
// free entries still remain for those PHVs. Anything that arrives while the
// FIFO is full, with no pop in the same cycle, is dropped and counted.
//
// Parameters:
//   PHV_LEN  PHV width in bits
//   DEPTH    number of entries (power of 2, >= SKID+2)
//   SKID     entries kept free for in-flight PHVs once ready deasserts
//   CW       occupancy counter width (derived)
//
// Ports:
//   axis_clk        in   clock, all logic on its rising edge
//   areset          in   asynchronous active-high reset
//   phv_in          in   PHV from the last stage
//   phv_in_valid    in   push request (producer ignores ready)
//   phv_fifo_ready  out  registered backpressure to the last stage
//   phv_out         out  head entry, valid while phv_out_valid = 1
//   phv_out_valid   out  FIFO non-empty
//   phv_out_ready   in   deparser accepts the head entry
//   count           out  current occupancy
//   overflow        out  sticky: at least one PHV was dropped
//   drop_cnt        out  dropped-PHV count, saturating at 0xFFFF
// -----------------------------------------------------------------------------
module phv_out_fifo #(
    parameter int PHV_LEN = 1024,
    parameter int DEPTH   = 8,
    parameter int SKID    = 3,
    parameter int CW      = $clog2(DEPTH) + 1
) (
    input  logic               axis_clk,
    input  logic               areset,
    input  logic [PHV_LEN-1:0] phv_in,
    input  logic               phv_in_valid,
    output logic               phv_fifo_ready,
    output logic [PHV_LEN-1:0] phv_out,
    output logic               phv_out_valid,
    input  logic               phv_out_ready,
    output logic [CW-1:0]      count,
    output logic               overflow,
    output logic [15:0]        drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
    localparam logic [CW-1:0] READY_LVL = CW'(DEPTH - SKID);

    // Saturating increment for the drop counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [PHV_LEN-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      count_next;
    logic               push;
    logic               pop;
    logic               drop;

    assign phv_out_valid = (count != '0);
    assign phv_out       = mem[rd_ptr];

    assign pop  = phv_out_valid && phv_out_ready;
    // A pop in the same cycle frees the head slot, so a push at full still lands.
    assign push = phv_in_valid && ((count < FULL_LVL) || pop);
    assign drop = phv_in_valid && !push;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (!push && pop) begin
            count_next = count - CW'(1);
        end
    end

    // Storage is data only: no reset, contents are simply forgotten when the
    // pointers clear.
    always_ff @(posedge axis_clk) begin
        if (push) begin
            mem[wr_ptr] <= phv_in;
        end
    end

    always_ff @(posedge axis_clk or posedge areset) begin
        if (areset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            overflow       <= 1'b0;
            drop_cnt       <= 16'd0;
            phv_fifo_ready <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
                drop_cnt <= sat_inc16(drop_cnt);
            end
            count <= count_next;
            // Registered from the next occupancy, so ready lags count by one edge
            // and the SKID reserve absorbs the producer's in-flight PHVs.
            phv_fifo_ready <= (count_next < READY_LVL);
        end
    end

endmodule

// File: doc/phv_out_fifo.md
# phv_out_fifo

Receive-side buffer for the PHV output of the final pipeline stage. It accepts `phv_in`/`phv_in_valid` from the last stage and returns `phv_fifo_ready` as that stage's backpressure input. It stores PHVs in order and presents them first-word-fall-through to the deparser through a valid/ready handshake. The producer registers its output and can have up to `SKID` PHVs in flight after ready drops, so ready deasserts early enough to leave headroom for them.

## Interface
- `PHV_LEN`, default 1024 (48*8+32*8+16*8+256): PHV width in bits.
- `DEPTH`, default 8: number of entries; must be a power of 2 and ≥ `SKID`+2.
- `SKID`, default 3: entries reserved for in-flight PHVs after ready deasserts.
- `CW`, default $clog2(DEPTH)+1: occupancy counter width (derived).

Ports:
- `axis_clk`  in  1  single clock; all logic is on its rising edge.
- `areset`  in  1  reset, asynchronous, active-high.
- `phv_in`  in  PHV_LEN  PHV from the last stage.
- `phv_in_valid`  in  1  push request. The producer does not wait for ready.
- `phv_fifo_ready`  out  1  registered backpressure signal to the last stage.
- `phv_out`  out  PHV_LEN  head entry (FWFT).
- `phv_out_valid`  out  1  FIFO is non-empty.
- `phv_out_ready`  in  1  deparser accepts the head entry.
- `count`  out  CW  current occupancy.
- `overflow`  out  1  sticky flag: at least one PHV was dropped.
- `drop_cnt`  out  16  number of dropped PHVs, saturating at 0xFFFF.

## Operation
- Storage: register array `mem[DEPTH]`, with `wr_ptr`/`rd_ptr` of $clog2(DEPTH) bits that wrap modulo DEPTH, and `count` of CW bits.
- Pop: `pop = phv_out_valid && phv_out_ready`.
- Push acceptance: `push = phv_in_valid && (count < DEPTH || pop)`. An accepted push writes `mem[wr_ptr]` and increments `wr_ptr`.
- Drop: `phv_in_valid && !push` (FIFO full and no pop in the same cycle).
  - The PHV is discarded and the FIFO state is unchanged.
  - `overflow` is set to 1.
  - `drop_cnt` increments unless it is already 0xFFFF.
- Pop action: increments `rd_ptr`.
- Count update: `count_next = count + push − pop`.
  - Push and pop in the same cycle leave `count` unchanged.
  - This holds at full (no drop) and at empty.
  - At empty, pop is impossible because `phv_out_valid` = 0, so the push simply lands.
- Outputs:
  - `phv_out = mem[rd_ptr]`, combinational read.
  - `phv_out_valid = (count != 0)`.
  - `phv_out` is don't-care while `phv_out_valid` = 0.
- Ready: `phv_fifo_ready <= (count_next < DEPTH − SKID)`, updated every cycle.
- Ordering: strictly FIFO. There is no reordering or filtering; queue bits [141+:4] pass through untouched.
- Reset (asynchronous, mid-operation included) clears all state immediately, regardless of clock:
  - `wr_ptr`, `rd_ptr`, `count` = 0.
  - `overflow` = 0, `drop_cnt` = 0.
  - `phv_fifo_ready` = 1, `phv_out_valid` = 0.
  - Stored contents are lost; `mem` itself is not reset.
  - A push presented on the first edge after reset release is accepted.

## Timing
- Push-to-output latency is 1 cycle. A PHV accepted on edge N appears on `phv_out` with `phv_out_valid` = 1 after edge N when the FIFO was empty; otherwise it appears behind older entries.
- Pop takes effect on the edge where `pop` = 1. The next entry, or `phv_out_valid` = 0, is visible after that edge.
- `phv_fifo_ready` lags occupancy by exactly one edge (registered from `count_next`).
  - With defaults, ready falls after the edge that makes `count` = 5.
  - Three more PHVs then fit without loss, which is the `SKID` headroom.
- `count`, `overflow` and `drop_cnt` update on the same edge as the push/pop/drop that causes them.

## Test plan
- Reset values: assert `areset` for 3 cycles, then release.
  - Required: `count` = 0, `phv_fifo_ready` = 1, `phv_out_valid` = 0, `overflow` = 0, `drop_cnt` = 0.
- Single PHV: push one PHV with all bytes 0xA5 while `phv_out_ready` = 0.
  - One edge later: `phv_out_valid` = 1, `phv_out` = 0xA5…A5, `count` = 1.
  - Then assert `phv_out_ready` for 1 cycle: `phv_out_valid` = 0, `count` = 0.
- Fill, skid and drop: `phv_out_ready` = 0; push values 1..9 on consecutive cycles.
  - `phv_fifo_ready` = 0 after the 5th push.
  - Pushes 6–8 are accepted; `count` = 8.
  - Push 9 is dropped: `overflow` = 1, `drop_cnt` = 1.
  - Draining yields 1..8 in order; `phv_fifo_ready` = 1 once `count` ≤ 4.
- Simultaneous at full: with `count` = 8, push 0x55 and assert `phv_out_ready` in the same cycle.
  - Required: `count` stays 8, `drop_cnt` unchanged, 0x55 emerges last.
- Wrap-around: 40 cycles of random push/pop with incrementing data, occupancy kept between 1 and 7.
  - Required: output sequence is identical to the input sequence, and `overflow` stays 0.
- Async reset mid-operation: with `count` = 6, assert `areset` between clock edges.
  - Outputs are immediately at reset values, before the next edge.
  - After release, a new PHV 0x77 is output first.
